// File: rtl/uart_ws2812_core.sv
// 8N1 UART receiver plus WS2812 24-bit GRB pixel serializer; the two halves share only the clock and reset.
// Optional macro UART_RX_ERR_EN adds an o_rx_err one-cycle pulse on a stop bit that samples low.
module uart_ws2812_core #(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 115200,
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 8,
  parameter int TBIT_CYC = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
`ifdef UART_RX_ERR_EN
  output logic       o_rx_err,
`endif
  input  logic       i_pix_valid,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_dout,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int CYC_W        = $clog2(TBIT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t        rx_state;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;

  tx_state_t        tx_state;
  logic [23:0]      tx_shift;
  logic [4:0]       tx_bit;
  logic [CYC_W-1:0] tx_cyc;
  logic [CYC_W-1:0] high_cyc;

  // Synchronizer idles high so reset release is never seen as a start edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
`ifdef UART_RX_ERR_EN
      o_rx_err   <= 1'b0;
`endif
    end else begin
      o_rx_valid <= 1'b0;
`ifdef UART_RX_ERR_EN
      o_rx_err   <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at the stop-bit centre so an immediately following start edge is caught.
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              o_rx_data  <= rx_shift;
              o_rx_valid <= 1'b1;
            end
`ifdef UART_RX_ERR_EN
            else begin
              o_rx_err <= 1'b1;
            end
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign high_cyc = tx_shift[23] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_cyc   <= '0;
      o_dout   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          o_dout <= 1'b0;
          if (i_pix_valid) begin
            tx_shift <= {i_g, i_r, i_b};
            tx_bit   <= '0;
            tx_cyc   <= '0;
            o_busy   <= 1'b1;
            o_dout   <= 1'b1;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cyc == CYC_W'(TBIT_CYC - 1)) begin
            tx_cyc <= '0;
            if (tx_bit == 5'd23) begin
              o_busy   <= 1'b0;
              o_dout   <= 1'b0;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {tx_shift[22:0], 1'b0};
              o_dout   <= 1'b1;
            end
          end else begin
            tx_cyc <= tx_cyc + 1'b1;
            // Registered output: decide the level for the coming cycle index.
            o_dout <= (CYC_W'(tx_cyc + 1'b1) < high_cyc);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ws2812_core.sv
// Scoreboard bench for uart_ws2812_core: stimulus pushes expected bytes/pixels, monitors pop and compare.
// Build with UART_RX_ERR_EN defined to also check the framing-error pulse.
module tb_uart_ws2812_core;
  localparam int CPB = 104;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_pix_valid = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_dout, o_busy;
`ifdef UART_RX_ERR_EN
  logic       o_rx_err;
  int         err_pulses = 0;
`endif

  uart_ws2812_core dut (
    .CLK(CLK), .RST_N(RST_N), .i_rx(i_rx), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
`ifdef UART_RX_ERR_EN
    .o_rx_err(o_rx_err),
`endif
    .i_pix_valid(i_pix_valid), .i_r(i_r), .i_g(i_g), .i_b(i_b), .o_dout(o_dout), .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } rx_exp_t;
  rx_exp_t     rx_q[$];
  logic [23:0] pix_q[$];
  int          frame_start[$];
  int          rx_strobes = 0;
  int          pix_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // UART scoreboard monitor
  initial begin
    rx_exp_t e;
    int lat;
    forever begin
      @(negedge CLK);
      if (RST_N && o_rx_valid) begin
        rx_strobes++;
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected_strobe actual=%0h required=none", o_rx_data);
        end else begin
          e = rx_q.pop_front();
          lat = cyc - e.start;
          if (o_rx_data !== e.data) begin
            errors++;
            $display("FAIL rx_data actual=%0h required=%0h", o_rx_data, e.data);
          end else begin
            $display("ok   rx_data = %0h", o_rx_data);
          end
          checks++;
          if (lat < 987 || lat > 993) begin
            errors++;
            $display("FAIL rx_latency actual=%0d required=987..993", lat);
          end
        end
      end
`ifdef UART_RX_ERR_EN
      if (RST_N && o_rx_err) err_pulses++;
`endif
    end
  end

  // Pixel scoreboard monitor: decode each 15-clock window by its high time
  initial begin
    logic [23:0] word;
    logic [23:0] exp_word;
    int h;
    bit aborted;
    bit shape_ok;
    forever begin
      @(negedge CLK);
      if (RST_N && o_busy) begin
        word = '0;
        aborted = 0;
        shape_ok = 1;
        frame_start.push_back(cyc);
        for (int b = 0; b < 24 && !aborted; b++) begin
          h = 0;
          for (int c = 0; c < 15 && !aborted; c++) begin
            if (!RST_N) begin
              aborted = 1;
            end else begin
              if (!o_busy) shape_ok = 0;
              if (o_dout) begin
                if (c != h) shape_ok = 0;
                h++;
              end
              @(negedge CLK);
            end
          end
          if (!aborted) begin
            if (h == 8) word[23-b] = 1'b1;
            else if (h != 4) shape_ok = 0;
          end
        end
        if (aborted || !RST_N) begin
          void'(frame_start.pop_back());
        end else begin
          pix_frames++;
          check("pix_busy_fall", {31'b0, o_busy}, 32'd0);
          check("pix_bit_shape", {31'b0, shape_ok}, 32'd1);
          checks++;
          if (pix_q.size() == 0) begin
            errors++;
            $display("FAIL pix_unexpected_frame actual=%06h required=none", word);
          end else begin
            exp_word = pix_q.pop_front();
            if (word !== exp_word) begin
              errors++;
              $display("FAIL pix_word actual=%06h required=%06h", word, exp_word);
            end else begin
              $display("ok   pix_word = %06h", word);
            end
          end
        end
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input logic stop_bit, input bit expect_ok);
    @(negedge CLK);
    if (expect_ok) rx_q.push_back('{b, cyc});
    i_rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    i_rx = stop_bit;
    repeat (CPB) @(negedge CLK);
    i_rx = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit expect_frame);
    @(negedge CLK);
    i_r = r; i_g = g; i_b = b;
    i_pix_valid = 1'b1;
    if (expect_frame) pix_q.push_back({g, r, b});
    @(negedge CLK);
    i_pix_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_dout", {31'b0, o_dout}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_rx_valid", {31'b0, o_rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, o_rx_data}, 32'h00);
`ifdef UART_RX_ERR_EN
    check("rst_rx_err", {31'b0, o_rx_err}, 32'd0);
`endif
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // UART: good frame, glitch, good frame, framing error
    uart_send(8'hA5, 1'b1, 1);
    @(negedge CLK);
    i_rx = 1'b0;
    repeat (20) @(negedge CLK);
    i_rx = 1'b1;
    repeat (150) @(negedge CLK);
    uart_send(8'h3C, 1'b1, 1);
    uart_send(8'h55, 1'b0, 0);
    repeat (10) @(negedge CLK);
    check("rx_hold_after_ferr", {24'b0, o_rx_data}, 32'h3C);
    check("rx_strobe_count", rx_strobes, 32'd2);
`ifdef UART_RX_ERR_EN
    check("rx_err_pulses", err_pulses, 32'd1);
`endif

    // Pixel 0x004080 with a stray valid pulse mid-frame
    send_pixel(8'h40, 8'h00, 8'h80, 1);
    repeat (180) @(negedge CLK);
    i_r = 8'hFF; i_g = 8'hFF; i_b = 8'hFF;
    i_pix_valid = 1'b1;
    @(negedge CLK);
    i_pix_valid = 1'b0;
    repeat (200) @(negedge CLK);
    check("pix_frames_single", pix_frames, 32'd1);

    // Continuous valid: two back-to-back frames, colours changed while busy
    @(negedge CLK);
    i_r = 8'h11; i_g = 8'h22; i_b = 8'h33;
    i_pix_valid = 1'b1;
    pix_q.push_back(24'h221133);
    @(negedge CLK);
    i_r = 8'hAA; i_g = 8'h0F; i_b = 8'hF0;
    pix_q.push_back(24'h0FAAF0);
    repeat (400) @(negedge CLK);
    i_pix_valid = 1'b0;
    repeat (400) @(negedge CLK);
    check("pix_frames_b2b", pix_frames, 32'd3);
    if (frame_start.size() >= 3)
      check("pix_b2b_gap", frame_start[2] - frame_start[1], 32'd361);

    // Both halves active together
    fork
      send_pixel(8'hFF, 8'h00, 8'h01, 1);
      uart_send(8'h81, 1'b1, 1);
    join
    repeat (50) @(negedge CLK);
    check("pix_frames_concurrent", pix_frames, 32'd4);
    check("rx_strobes_concurrent", rx_strobes, 32'd3);

    // Asynchronous reset mid-pixel while the line is high
    send_pixel(8'hFF, 8'hFF, 8'hFF, 0);
    repeat (2) @(negedge CLK);
    check("pre_rst_dout_high", {31'b0, o_dout}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_dout", {31'b0, o_dout}, 32'd0);
    check("async_rst_busy", {31'b0, o_busy}, 32'd0);
    check("async_rst_rx_data", {24'b0, o_rx_data}, 32'h00);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    send_pixel(8'h01, 8'h80, 8'h7E, 1);
    repeat (400) @(negedge CLK);
    check("pix_frames_after_rst", pix_frames, 32'd5);
    check("pix_queue_empty", pix_q.size(), 32'd0);
    check("rx_queue_empty", rx_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
